// File: rtl/data_mem_resp.sv
// Data-memory responder: serialised valid/ready load/store with byte-lane stores,
// WAIT_CYCLES access delay and registered responses. Optional DMEM_ADDR_CHECK_EN faults bad accesses.
module data_mem_resp #(
    parameter int DEPTH_LOG2  = 10,
    parameter int WAIT_CYCLES = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [3:0]  req_be,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);
    localparam int DEPTH = 1 << DEPTH_LOG2;

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] wdata_q, wdata_d;
    logic        req_ready_q, req_ready_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic        rsp_err_q, rsp_err_d;

    logic [DEPTH_LOG2-1:0] word_idx;
    logic                  fault;
    logic                  access_go;
    logic                  rsp_done;
    logic                  wr_en;
    logic                  rd_en;

    assign word_idx  = addr_q[DEPTH_LOG2+1:2];
    assign access_go = (state_q == ACCESS) && (cnt_q == 4'd0);
    assign rsp_done  = (state_q == RESP) && rsp_ready;
    // A store landing on the same edge as reset is abandoned, not committed.
    assign wr_en     = access_go && we_q && !fault && !rst;
    assign rd_en     = access_go && !we_q && !fault;

`ifdef DMEM_ADDR_CHECK_EN
    assign fault = ((addr_q >> (DEPTH_LOG2 + 2)) != 32'd0) ||
                   (we_q && (be_q == 4'b1111) && (addr_q[1:0] != 2'b00));
`else
    logic unused_addr_bits;
    assign fault            = 1'b0;
    assign unused_addr_bits = ^{addr_q[31:DEPTH_LOG2+2], addr_q[1:0]};
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            we_q        <= 1'b0;
            addr_q      <= 32'd0;
            be_q        <= 4'd0;
            wdata_q     <= 32'd0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            be_q        <= be_d;
            wdata_q     <= wdata_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        we_d        = we_q;
        addr_d      = addr_q;
        be_d        = be_q;
        wdata_d     = wdata_q;
        req_ready_d = req_ready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_err_d   = rsp_err_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    we_d        = req_we;
                    addr_d      = req_addr;
                    be_d        = req_be;
                    wdata_d     = req_wdata;
                    cnt_d       = 4'(WAIT_CYCLES);
                    req_ready_d = 1'b0;
                    state_d     = ACCESS;
                end
            end
            ACCESS: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = fault;
                    state_d     = RESP;
                end
            end
            RESP: begin
                // Completion edge returns to IDLE only; acceptance waits a cycle.
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    rsp_err_d   = 1'b0;
                    req_ready_d = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d     = IDLE;
                req_ready_d = 1'b1;
                rsp_valid_d = 1'b0;
                rsp_err_d   = 1'b0;
            end
        endcase
    end

    // One byte-wide array per lane so each maps onto a plain RAM with its own write enable.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] mem_q [DEPTH];
            logic [7:0] rdata_q;

            always_ff @(posedge clk) begin
                if (wr_en && be_q[gi]) begin
                    mem_q[word_idx] <= wdata_q[gi*8 +: 8];
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    rdata_q <= 8'd0;
                end else if (rd_en) begin
                    rdata_q <= mem_q[word_idx];
                end else if (rsp_done) begin
                    rdata_q <= 8'd0;
                end
            end

            assign rsp_rdata[gi*8 +: 8] = rdata_q;
        end
    endgenerate

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_data_mem_resp.sv
// Bench for data_mem_resp: a WAIT_CYCLES=0 and a WAIT_CYCLES=3 instance, table-driven
// transactions with a response scoreboard, plus stall and mid-access reset sequences.
module tb_data_mem_resp;
    logic clk = 1'b0;
    always #5 clk = ~clk;

`ifdef DMEM_ADDR_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic        rst, sel;
    logic        req_valid, req_we, rsp_ready;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_be;

    logic        req_valid0, req_valid1, rsp_ready0, rsp_ready1;
    logic        req_ready0, req_ready1, rsp_valid0, rsp_valid1, rsp_err0, rsp_err1;
    logic [31:0] rsp_rdata0, rsp_rdata1;
    logic        req_ready_s, rsp_valid_s, rsp_err_s;
    logic [31:0] rsp_rdata_s;

    assign req_valid0  = req_valid & ~sel;
    assign req_valid1  = req_valid & sel;
    assign rsp_ready0  = rsp_ready & ~sel;
    assign rsp_ready1  = rsp_ready & sel;
    assign req_ready_s = sel ? req_ready1 : req_ready0;
    assign rsp_valid_s = sel ? rsp_valid1 : rsp_valid0;
    assign rsp_err_s   = sel ? rsp_err1   : rsp_err0;
    assign rsp_rdata_s = sel ? rsp_rdata1 : rsp_rdata0;

    data_mem_resp #(.DEPTH_LOG2(10), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid0), .req_ready(req_ready0), .req_we(req_we),
        .req_addr(req_addr), .req_be(req_be), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid0), .rsp_ready(rsp_ready0),
        .rsp_rdata(rsp_rdata0), .rsp_err(rsp_err0)
    );

    data_mem_resp #(.DEPTH_LOG2(10), .WAIT_CYCLES(3)) dut3 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid1), .req_ready(req_ready1), .req_we(req_we),
        .req_addr(req_addr), .req_be(req_be), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready1),
        .rsp_rdata(rsp_rdata1), .rsp_err(rsp_err1)
    );

    int n_checks = 0;
    int n_errors = 0;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } rsp_t;
    rsp_t exp_q[$];

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        string       name;
    } vec_t;
    vec_t vecs[$];

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic add_vec(input logic we, input logic [31:0] addr, input logic [3:0] be,
                           input logic [31:0] wd, input logic [31:0] er, input logic ee,
                           input string name);
        vec_t v;
        v.we = we; v.addr = addr; v.be = be; v.wdata = wd;
        v.exp_rdata = er; v.exp_err = ee; v.name = name;
        vecs.push_back(v);
    endtask

    // Scoreboard: every completed response handshake pops one expectation.
    always @(negedge clk) begin
        if (!rst && rsp_valid_s && rsp_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL spurious_rsp: got response rdata=0x%08h err=%0d, expected none",
                         rsp_rdata_s, rsp_err_s);
            end else begin
                rsp_t e;
                e = exp_q.pop_front();
                check32("sb_rdata", rsp_rdata_s, e.rdata);
                check32("sb_err", 32'(rsp_err_s), 32'(e.err));
            end
        end
    end

    task automatic do_txn(input logic we, input logic [31:0] addr, input logic [3:0] be,
                          input logic [31:0] wd, input logic [31:0] exp_rd, input logic exp_err,
                          input int stall, input string name);
        int   lat;
        int   wait_exp;
        rsp_t e;
        wait_exp = sel ? 3 : 0;
        check32({name, "/ready_idle"}, 32'(req_ready_s), 32'd1);
        req_valid = 1'b1; req_we = we; req_addr = addr; req_be = be; req_wdata = wd;
        e.rdata = exp_rd; e.err = exp_err;
        exp_q.push_back(e);
        @(posedge clk); #1;
        // Scramble request inputs after acceptance; the DUT must ignore them.
        req_addr = addr ^ 32'h0000_0F0C; req_wdata = ~wd; req_we = ~we;
        check32({name, "/ready_busy"}, 32'(req_ready_s), 32'd0);
        lat = 0;
        do begin
            req_valid = ~req_valid;
            @(posedge clk); #1;
            lat++;
        end while (!rsp_valid_s && lat < 40);
        check32({name, "/latency"}, 32'(lat), 32'(wait_exp + 1));
        for (int k = 0; k < stall; k++) begin
            req_valid = ~req_valid;
            @(posedge clk); #1;
            check32({name, "/stall_valid"}, 32'(rsp_valid_s), 32'd1);
            check32({name, "/stall_rdata"}, rsp_rdata_s, exp_rd);
            check32({name, "/stall_ready"}, 32'(req_ready_s), 32'd0);
        end
        rsp_ready = 1'b1; req_valid = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0; req_valid = 1'b0;
        check32({name, "/done_valid"}, 32'(rsp_valid_s), 32'd0);
        check32({name, "/done_ready"}, 32'(req_ready_s), 32'd1);
        check32({name, "/done_rdata"}, rsp_rdata_s, 32'd0);
        $display("txn %-12s dut=W%0d we=%0d addr=0x%08h be=%b wdata=0x%08h exp_rdata=0x%08h exp_err=%0d lat=%0d",
                 name, wait_exp, we, addr, be, wd, exp_rd, exp_err, lat);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; sel = 1'b0;
        req_valid = 1'b0; req_we = 1'b0; req_addr = 32'd0; req_be = 4'd0; req_wdata = 32'd0;
        rsp_ready = 1'b0;

        add_vec(1, 32'h10,   4'b1111, 32'hDEADBEEF, 32'h0,        0, "st_word");
        add_vec(0, 32'h10,   4'b0000, 32'h0,        32'hDEADBEEF, 0, "ld_word");
        add_vec(1, 32'h11,   4'b0100, 32'h00AA0000, 32'h0,        0, "st_lane2");
        add_vec(0, 32'h10,   4'b1111, 32'h0,        32'hDEAABEEF, 0, "ld_merged");
        add_vec(0, 32'h13,   4'b0000, 32'h0,        32'hDEAABEEF, 0, "ld_lowbits");
        add_vec(1, 32'h14,   4'b1111, 32'h01234567, 32'h0,        0, "st_w14");
        add_vec(1, 32'h14,   4'b0000, 32'hFFFFFFFF, 32'h0,        0, "st_be0");
        add_vec(0, 32'h14,   4'b0000, 32'h0,        32'h01234567, 0, "ld_be0");
        add_vec(1, 32'h18,   4'b1111, 32'h11223344, 32'h0,        0, "st_w18");
        add_vec(1, 32'h18,   4'b1001, 32'hAABBCCDD, 32'h0,        0, "st_lane30");
        add_vec(0, 32'h18,   4'b0000, 32'h0,        32'hAA2233DD, 0, "ld_lane30");
        add_vec(1, 32'h1B,   4'b0001, 32'h000000EE, 32'h0,        0, "st_lane0");
        add_vec(0, 32'h18,   4'b0000, 32'h0,        32'hAA2233EE, 0, "ld_lane0");
        add_vec(1, 32'h0,    4'b1111, 32'h0BADF00D, 32'h0,        0, "st_w0");
        add_vec(1, 32'h1000, 4'b1111, 32'hCAFEBABE, 32'h0,        CHK, "st_oor");
        add_vec(0, 32'h0,    4'b0000, 32'h0, CHK ? 32'h0BADF00D : 32'hCAFEBABE, 0, "ld_w0");
        add_vec(1, 32'h20,   4'b1111, 32'h20202020, 32'h0,        0, "st_w20");
        add_vec(1, 32'h22,   4'b1111, 32'h55555555, 32'h0,        CHK, "st_misalign");
        add_vec(0, 32'h20,   4'b0000, 32'h0, CHK ? 32'h20202020 : 32'h55555555, 0, "ld_w20");
        add_vec(0, 32'h1010, 4'b0000, 32'h0, CHK ? 32'h0 : 32'hDEAABEEF, CHK, "ld_1010");

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check32("rst/req_ready0", 32'(req_ready0), 32'd1);
        check32("rst/rsp_valid0", 32'(rsp_valid0), 32'd0);
        check32("rst/rsp_rdata0", rsp_rdata0, 32'd0);
        check32("rst/rsp_err0", 32'(rsp_err0), 32'd0);
        check32("rst/req_ready3", 32'(req_ready1), 32'd1);
        check32("rst/rsp_valid3", 32'(rsp_valid1), 32'd0);
        check32("rst/rsp_rdata3", rsp_rdata1, 32'd0);
        check32("rst/rsp_err3", 32'(rsp_err1), 32'd0);

        for (int i = 0; i < vecs.size(); i++) begin
            do_txn(vecs[i].we, vecs[i].addr, vecs[i].be, vecs[i].wdata,
                   vecs[i].exp_rdata, vecs[i].exp_err, i % 3, vecs[i].name);
        end

        sel = 1'b1;
        @(posedge clk); #1;
        do_txn(1, 32'h20, 4'b1111, 32'h13572468, 32'h0,        0, 0, "w3_st20");
        do_txn(0, 32'h20, 4'b0000, 32'h0,        32'h13572468, 0, 5, "w3_ld_stall");

        // Reset while a store sits in ACCESS: the store must never land.
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20; req_be = 4'b1111; req_wdata = 32'hFFFFFFFF;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check32("abort/accepted", 32'(req_ready_s), 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check32("abort/req_ready", 32'(req_ready_s), 32'd1);
        check32("abort/rsp_valid", 32'(rsp_valid_s), 32'd0);
        repeat (6) @(posedge clk);
        #1;
        check32("abort/no_rsp", 32'(rsp_valid_s), 32'd0);
        $display("txn abort_st20  dut=W3 we=1 addr=0x00000020 reset in ACCESS, no response expected");
        do_txn(0, 32'h20, 4'b0000, 32'h0, 32'h13572468, 0, 1, "w3_ld_after");

        repeat (2) @(posedge clk);
        #1;
        check32("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
